// File: rtl/snn_pkg.sv
// Shared types and helpers for the two-layer classifier core, its loader and
// its bench: FSM state encoding, derived width helpers and the hidden clamp.
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HID_MAC,
    S_HID_WB,
    S_OUT_MAC,
    S_OUT_CMP,
    S_DONE
  } state_t;

  // Wide enough for N_IN sign-extended weights without overflow.
  function automatic int hacc_width(input int w_w, input int n_in);
    return w_w + $clog2(n_in) + 1;
  endfunction

  // Wide enough for N_HID products of a signed weight and an unsigned byte.
  function automatic int oacc_width(input int w_w, input int n_hid);
    return w_w + 8 + $clog2(n_hid) + 1;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

endpackage

// File: rtl/snn_mac_acc.sv
// Clearable accumulator; 'sum' already contains the current term so the
// final lagged term of a dot product can be consumed in the clear cycle.
module snn_mac_acc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] sum
);

  logic [W-1:0] acc;

  assign sum = en ? acc + term : acc;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else            acc <= sum;
  end

endmodule

// File: rtl/snn_mlp_core.sv
// Two-layer binary-input classifier: streams pixels and weights from external
// synchronous memories, computes clamped-ReLU hidden units, then argmax output.
module snn_mlp_core
  import snn_pkg::*;
#(
  parameter  int N_IN      = 784,
  parameter  int N_HID     = 32,
  parameter  int N_OUT     = 10,
  parameter  int W_W       = 8,
  parameter  int HID_SHIFT = 4,
  localparam int IA        = $clog2(N_IN),
  localparam int HWA       = $clog2(N_IN * N_HID),
  localparam int OWA       = $clog2(N_HID * N_OUT),
  localparam int DW        = $clog2(N_OUT),
  localparam int HACC      = hacc_width(W_W, N_IN),
  localparam int OACC      = oacc_width(W_W, N_HID)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [IA-1:0]   addr_input_unit,
  input  logic            q_input,
  output logic [HWA-1:0]  addr_w_hid,
  input  logic [W_W-1:0]  q_w_hid,
  output logic [OWA-1:0]  addr_w_out,
  input  logic [W_W-1:0]  q_w_out,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   digit,
  output logic [OACC-1:0] score
);

  localparam int HB = idx_width(N_HID);

  state_t state, state_nxt;

  logic [HB-1:0]          h_cnt, h_rd;
  logic [DW-1:0]          o_cnt, best_idx;
  logic signed [OACC-1:0] best;
  logic                   hid_mac_v, out_mac_v;
  logic                   i_last, h_last, o_last;

  logic [HACC-1:0]        hid_term, hid_sum;
  logic [7:0]             hid_act, hid_rd_val;
  logic [7:0]             hid_mem [N_HID];

  logic signed [W_W+8:0]  w_ext, h_ext, prod;
  logic [OACC-1:0]        out_term, out_sum;

  assign i_last = (addr_input_unit == IA'(N_IN - 1));
  assign h_last = (h_cnt == HB'(N_HID - 1));
  assign o_last = (o_cnt == DW'(N_OUT - 1));

  // Hidden layer: memory data lags its address by one cycle, hence hid_mac_v.
  assign hid_term = q_input ? HACC'($signed(q_w_hid)) : '0;
  assign hid_act  = clamp_u8(32'($signed(hid_sum) >>> HID_SHIFT));

  snn_mac_acc #(.W(HACC)) u_hid_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_HID_WB),
    .en   (hid_mac_v),
    .term (hid_term),
    .sum  (hid_sum)
  );

  // Output layer: h_rd trails h_cnt so the activation lines up with ROM data.
  assign hid_rd_val = hid_mem[h_rd];
  assign w_ext      = (W_W + 9)'($signed(q_w_out));
  assign h_ext      = {{(W_W + 1){1'b0}}, hid_rd_val};
  assign prod       = w_ext * h_ext;
  assign out_term   = OACC'(prod);

  snn_mac_acc #(.W(OACC)) u_out_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_OUT_CMP),
    .en   (out_mac_v),
    .term (out_term),
    .sum  (out_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaulting state_nxt before the case keeps this purely combinational
  // (no latch) even when a branch leaves it untouched.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_HID_MAC;
      S_HID_MAC: if (i_last) state_nxt = S_HID_WB;
      S_HID_WB:  state_nxt = h_last ? S_OUT_MAC : S_HID_MAC;
      S_OUT_MAC: if (h_last) state_nxt = S_OUT_CMP;
      S_OUT_CMP: state_nxt = o_last ? S_DONE : S_OUT_MAC;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_input_unit <= '0;
      addr_w_hid      <= '0;
      addr_w_out      <= '0;
      h_cnt           <= '0;
      h_rd            <= '0;
      o_cnt           <= '0;
      hid_mac_v       <= 1'b0;
      out_mac_v       <= 1'b0;
      best            <= '0;
      best_idx        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      digit           <= '0;
      score           <= '0;
    end else begin
      hid_mac_v <= (state == S_HID_MAC);
      out_mac_v <= (state == S_OUT_MAC);
      h_rd      <= h_cnt;
      done      <= (state == S_DONE);
      busy      <= (state_nxt != S_IDLE) || (state == S_DONE);
      case (state)
        S_IDLE: begin
          addr_input_unit <= '0;
          addr_w_hid      <= '0;
          addr_w_out      <= '0;
          h_cnt           <= '0;
          o_cnt           <= '0;
        end
        S_HID_MAC: begin
          // Hidden ROM is h-major, so its address simply walks forward.
          addr_input_unit <= i_last ? '0 : addr_input_unit + IA'(1);
          addr_w_hid      <= (i_last && h_last) ? '0 : addr_w_hid + HWA'(1);
        end
        S_HID_WB: h_cnt <= h_last ? '0 : h_cnt + HB'(1);
        S_OUT_MAC: begin
          h_cnt      <= h_last ? '0 : h_cnt + HB'(1);
          addr_w_out <= (h_last && o_last) ? '0 : addr_w_out + OWA'(1);
        end
        S_OUT_CMP: begin
          // Strict compare keeps the lowest class index on ties.
          if (o_cnt == '0 || $signed(out_sum) > best) begin
            best     <= $signed(out_sum);
            best_idx <= o_cnt;
          end
          o_cnt <= o_last ? '0 : o_cnt + DW'(1);
        end
        S_DONE: begin
          digit <= best_idx;
          score <= best;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the hidden register file has no reset; each entry is written in
  // HID_WB before the output layer can read it.
  always_ff @(posedge clk) begin
    if (state == S_HID_WB) hid_mem[h_cnt] <= hid_act;
  end

endmodule

// File: tb/tb_snn_mlp_core.sv
// Directed bench for snn_mlp_core in a 4-2-3 configuration with behavioural
// synchronous RAM/ROM models and hand-computed scores.
module tb_snn_mlp_core;

  localparam int N_IN  = 4;
  localparam int N_HID = 2;
  localparam int N_OUT = 3;
  localparam int W_W   = 8;
  localparam int L     = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         addr_input_unit;
  logic               q_input;
  logic [2:0]         addr_w_hid;
  logic [7:0]         q_w_hid;
  logic [2:0]         addr_w_out;
  logic [7:0]         q_w_out;
  logic               busy;
  logic               done;
  logic [1:0]         digit;
  logic signed [17:0] score;

  logic               pix [4];
  logic signed [7:0]  wh  [8];
  logic signed [7:0]  wo  [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_input <= pix[addr_input_unit];
    q_w_hid <= wh[addr_w_hid];
    q_w_out <= wo[addr_w_out];
  end

  snn_mlp_core #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W_W(W_W), .HID_SHIFT(0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .addr_w_hid      (addr_w_hid),
    .q_w_hid         (q_w_hid),
    .addr_w_out      (addr_w_out),
    .q_w_out         (q_w_out),
    .busy            (busy),
    .done            (done),
    .digit           (digit),
    .score           (score)
  );

  task automatic check(input string tag, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic set_pix(input logic p0, input logic p1, input logic p2, input logic p3);
    pix[0] = p0; pix[1] = p1; pix[2] = p2; pix[3] = p3;
  endtask

  task automatic set_hid(input int h, input int w0, input int w1, input int w2, input int w3);
    wh[h*4+0] = 8'(w0); wh[h*4+1] = 8'(w1); wh[h*4+2] = 8'(w2); wh[h*4+3] = 8'(w3);
  endtask

  task automatic set_out(input int o, input int w0, input int w1);
    wo[o*2+0] = 8'(w0); wo[o*2+1] = 8'(w1);
  endtask

  // Start one run, optionally poke start mid-run, and check latency and result.
  task automatic run_and_check(input string name, input bit poke,
                               input int exp_digit, input int exp_score);
    int cyc;
    bit seen;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, ":busy_rise"}, busy, 1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke && cyc == 7);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({name, ":latency"}, cyc, L);
    check({name, ":busy_done"}, busy, 1);
    check({name, ":digit"}, digit, exp_digit);
    check({name, ":score"}, score, exp_score);
    @(posedge clk);
    #1;
    check({name, ":done_pulse"}, done, 0);
    check({name, ":busy_fall"}, busy, 0);
    check({name, ":digit_held"}, digit, exp_digit);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wh[k] = '0;
      wo[k] = '0;
    end
    set_pix(1, 1, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst:done", done, 0);
    check("rst:busy", busy, 0);
    check("rst:digit", digit, 0);
    check("rst:score", score, 0);
    check("rst:addr_in", addr_input_unit, 0);
    check("rst:addr_wh", addr_w_hid, 0);
    check("rst:addr_wo", addr_w_out, 0);
    @(negedge clk) rst = 1'b0;

    // hid = {12,12}; scores {-24,-24,24}
    set_hid(0, 3, 3, 3, 3); set_hid(1, 3, 3, 3, 3);
    set_out(0, -1, -1); set_out(1, -1, -1); set_out(2, 1, 1);
    run_and_check("t1_basic", 1'b0, 2, 24);

    // hid acc -20 clamps to 0; all scores tie at 0
    set_hid(0, -5, -5, -5, -5); set_hid(1, -5, -5, -5, -5);
    run_and_check("t2_clamp_lo", 1'b0, 0, 0);

    // hid acc 508 clamps to 255; class1 = 255+255
    set_hid(0, 127, 127, 127, 127); set_hid(1, 127, 127, 127, 127);
    set_out(0, 0, 0); set_out(1, 1, 1); set_out(2, 0, 0);
    run_and_check("t3_clamp_hi", 1'b0, 1, 510);

    // pixel 1 off: hid = {27,97}; scores {-43,113,-3359}
    set_pix(1, 0, 1, 1);
    set_hid(0, 10, -100, 20, -3); set_hid(1, -7, 50, 4, 100);
    set_out(0, 2, -1); set_out(1, -3, 2); set_out(2, -128, 1);
    run_and_check("t4_mixed", 1'b0, 1, 113);

    // scores {54,0,54}: tie goes to class 0; mid-run start is ignored
    set_out(0, 2, 0); set_out(1, 0, 0); set_out(2, 2, 0);
    run_and_check("t5_tie_poke", 1'b1, 0, 54);

    // hid = {12,12}; all scores negative {-24,-12,-48}
    set_pix(1, 1, 1, 1);
    set_hid(0, 3, 3, 3, 3); set_hid(1, 3, 3, 3, 3);
    set_out(0, -1, -1); set_out(1, -1, 0); set_out(2, -2, -2);
    run_and_check("t6_all_neg", 1'b0, 1, -12);

    // Reset ten cycles into a run, with a stray start pulse before it
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst:busy", busy, 0);
    check("midrst:done", done, 0);
    check("midrst:digit", digit, 0);
    check("midrst:score", score, 0);
    check("midrst:addr_wh", addr_w_hid, 0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst:quiet", seen, 0);

    set_pix(1, 0, 1, 1);
    set_hid(0, 10, -100, 20, -3); set_hid(1, -7, 50, 4, 100);
    set_out(0, 2, -1); set_out(1, -3, 2); set_out(2, -128, 1);
    run_and_check("t7_after_rst", 1'b0, 1, 113);

    // start held high: the second run starts on the edge ending the first done
    set_pix(1, 1, 1, 1);
    set_hid(0, 3, 3, 3, 3); set_hid(1, 3, 3, 3, 3);
    set_out(0, -1, -1); set_out(1, -1, -1); set_out(2, 1, 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check("b2b:latency1", cyc, L);
    check("b2b:digit1", digit, 2);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("b2b:gap", cyc, L + 1);
    check("b2b:score2", score, 24);
    @(posedge clk);
    #1;
    check("b2b:busy_fall", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
